piso_tx: RTL and testbench

Parallel-in serial-out transmitter that feeds the 4-bit `sipo` shift register stage. It accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per clock, LSB first by default. LSB-first order matches `sipo`, which shifts right and inserts at bit 3, so after WIDTH falling edges `sipo.out` equals the transmitted word. A one-word holding buffer lets consecutive words stream with no idle cycle between frames.

---
 rtl/piso_tx.sv | 94 +++++++++
 tb/tb_piso_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter feeding the sipo shift stage.
// Accepts words over valid/ready and streams one bit per clock, with a one-word holding buffer.
//
// state | meaning
// IDLE  | no frame in flight, ser_out parked at 0
// SHIFT | driving frame bits, cnt counts bits already sent in this frame
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hold_full, hold_full_n;
  logic             accept, at_end, load, load_from_hold;

  always_comb begin
    accept         = in_valid & in_ready;
    at_end         = (state == SHIFT) && (cnt == CNT_LAST);
    load           = ((state == IDLE) || at_end) && (hold_full || accept);
    load_from_hold = load & hold_full;

    state_n     = state;
    sh_n        = sh;
    cnt_n       = cnt;
    hold_n      = hold;
    hold_full_n = hold_full;

    if (load) begin
      sh_n    = load_from_hold ? hold : in_data;
      cnt_n   = '0;
      state_n = SHIFT;
    end else if (state == SHIFT) begin
      if (at_end) begin
        state_n = IDLE;
      end else begin
        sh_n  = MSB_FIRST ? (sh << 1) : (sh >> 1);
        cnt_n = cnt + 1'b1;
      end
    end

    // in_ready implies hold is empty, so draining and refilling never coincide
    if (load_from_hold)
      hold_full_n = 1'b0;
    if (accept && !(load && !hold_full)) begin
      hold_n      = in_data;
      hold_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      in_ready  <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      in_ready  <= ~hold_full_n;
      ser_out   <= (state_n == SHIFT) ? (MSB_FIRST ? sh_n[WIDTH-1] : sh_n[0]) : 1'b0;
      ser_valid <= (state_n == SHIFT);
      ser_last  <= (state_n == SHIFT) && (cnt_n == CNT_LAST);
      busy      <= (state_n == SHIFT) || hold_full_n;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: a 4-bit LSB-first instance chained to a sipo model,
// plus an 8-bit MSB-first instance.
module tb_piso_tx;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data4;
  logic       in_valid4, in_ready4, ser_out4, ser_valid4, ser_last4, busy4;
  logic [7:0] in_data8;
  logic       in_valid8, in_ready8, ser_out8, ser_valid8, ser_last8, busy8;
  logic [3:0] sipo;

  int ncmp = 0;
  int nerr = 0;
  int run4 = 0, last_run4 = 0, run8 = 0, last_run8 = 0;

  logic [1:0] q4[$];
  logic [1:0] q8[$];
  logic [3:0] qw[$];

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .ser_out(ser_out4), .ser_valid(ser_valid4),
    .ser_last(ser_last4), .busy(busy4));

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .ser_out(ser_out8), .ser_valid(ser_valid8),
    .ser_last(ser_last8), .busy(busy8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // downstream sipo: shifts right, inserts at bit 3, no reset
  always @(negedge clk) sipo <= {ser_out4, sipo[3:1]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // expected stream for the LSB-first 4-bit instance: {bit, last}
  task automatic push4(input logic [3:0] w);
    for (int i = 0; i < 4; i++) q4.push_back({w[i], i == 3});
    qw.push_back(w);
  endtask

  task automatic push8(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) q8.push_back({w[i], i == 0});
  endtask

  // monitor for the 4-bit instance and its sipo
  initial begin
    logic [1:0] e;
    logic [3:0] ew;
    forever begin
      @(negedge clk);
      #1;
      if (ser_valid4 === 1'b1) begin
        run4++;
        chk("busy4_during_frame", busy4, 1'b1);
        if (q4.size() == 0) begin
          chk("unexpected_bit4", 1, 0);
        end else begin
          e = q4.pop_front();
          chk("ser_out4", ser_out4, e[1]);
          chk("ser_last4", ser_last4, e[0]);
        end
        if (ser_last4 === 1'b1) begin
          if (qw.size() == 0) chk("unexpected_word_sipo", 1, 0);
          else begin
            ew = qw.pop_front();
            chk("sipo_out", sipo, ew);
          end
        end
      end else if (run4 > 0) begin
        last_run4 = run4;
        run4 = 0;
      end
    end
  end

  // monitor for the 8-bit MSB-first instance
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (ser_valid8 === 1'b1) begin
        run8++;
        if (q8.size() == 0) chk("unexpected_bit8", 1, 0);
        else begin
          e = q8.pop_front();
          chk("ser_out8", ser_out8, e[1]);
          chk("ser_last8", ser_last8, e[0]);
        end
      end else if (run8 > 0) begin
        last_run8 = run8;
        run8 = 0;
      end
    end
  end

  // offers w until accepted; acc returns the index of the accepting edge
  task automatic send4(input logic [3:0] w, input bit track, output int acc);
    logic rdy;
    bit   done;
    done = 0;
    acc = -1;
    in_data4  = w;
    in_valid4 = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      rdy = in_ready4;
      @(posedge clk);
      if (rdy) begin
        acc = int'(($time - 5) / 10);
        if (track) push4(w);
        done = 1;
      end
      #1;
    end
    if (!done) chk("accept_timeout4", 0, 1);
  endtask

  task automatic send8(input logic [7:0] w);
    logic rdy;
    bit   done;
    done = 0;
    in_data8  = w;
    in_valid8 = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      rdy = in_ready8;
      @(posedge clk);
      if (rdy) begin
        push8(w);
        done = 1;
      end
      #1;
    end
    in_valid8 = 1'b0;
    if (!done) chk("accept_timeout8", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (!busy4 && !busy8 && !ser_valid4 && !ser_valid8) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, a1, a2;
    rst_n = 1'b0;
    in_valid4 = 1'b1;
    in_data4 = 4'h9;
    in_valid8 = 1'b0;
    in_data8 = 8'h00;

    // reset values with in_valid held high
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready4, 1'b0);
      chk("rst_ser_valid", ser_valid4, 1'b0);
      chk("rst_busy", busy4, 1'b0);
      chk("rst_ser_out", ser_out4, 1'b0);
      chk("rst_ser_last", ser_last4, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", in_ready4, 1'b1);
    chk("rel_no_accept", ser_valid4, 1'b0);
    chk("rel_in_ready8", in_ready8, 1'b1);
    push4(4'h9);
    @(posedge clk);
    #1;
    chk("rel_first_transfer", ser_valid4, 1'b1);
    in_valid4 = 1'b0;
    wait_idle();
    chk("run_after_reset", last_run4, 4);

    // single word, latency check
    send4(4'b1011, 1, a0);
    in_valid4 = 1'b0;
    chk("latency_valid", ser_valid4, 1'b1);
    chk("latency_bit0", ser_out4, 1'b1);
    wait_idle();
    chk("run_single", last_run4, 4);
    chk("idle_ser_out", ser_out4, 1'b0);

    // back-to-back
    send4(4'hA, 1, a0);
    send4(4'h5, 1, a1);
    in_valid4 = 1'b0;
    chk("b2b_accept_gap", a1 - a0, 1);
    wait_idle();
    chk("run_b2b", last_run4, 8);

    // backpressure
    send4(4'h1, 1, a0);
    send4(4'h2, 1, a1);
    chk("bp_ready_drop", in_ready4, 1'b0);
    chk("bp_busy", busy4, 1'b1);
    send4(4'h3, 1, a2);
    in_valid4 = 1'b0;
    chk("bp_accept2", a1 - a0, 1);
    chk("bp_accept3", a2 - a0, 5);
    wait_idle();
    chk("run_bp", last_run4, 12);

    // reset mid-frame with a word in hold
    send4(4'hF, 0, a0);
    q4.push_back(2'b10);
    q4.push_back(2'b10);
    send4(4'h6, 0, a1);
    in_valid4 = 1'b0;
    chk("mid_hold_full", in_ready4, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", ser_valid4, 1'b0);
    chk("mid_rst_out", ser_out4, 1'b0);
    chk("mid_rst_last", ser_last4, 1'b0);
    chk("mid_rst_busy", busy4, 1'b0);
    chk("mid_rst_ready", in_ready4, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", in_ready4, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_no_resend_busy", busy4, 1'b0);
    chk("mid_queue_drained", q4.size(), 0);
    chk("mid_run", last_run4, 2);

    // MSB-first, 8 bits
    send8(8'hC5);
    wait_idle();
    chk("run_msb8", last_run8, 8);

    chk("q4_empty", q4.size(), 0);
    chk("q8_empty", q8.size(), 0);
    chk("qw_empty", qw.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
